// File: rtl/widen16to32_pkg.sv
// Shared width constants and controller state encoding for the 16->32 packing path.
package cpu_width_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 2 * HALF_W;

    typedef enum logic [1:0] {
        FIRST  = 2'b00,
        SECOND = 2'b01,
        FULL   = 2'b10
    } width_state_e;

endpackage

// File: rtl/widen16to32.sv
// Packs two half-word beats into one registered word behind valid/ready handshakes.
// Build option WIDEN16TO32_SEXT_EN adds in_sext: a single beat sign-extended to a full word.
module widen16to32
    import cpu_width_pkg::*;
#(
    parameter int HALF_W    = cpu_width_pkg::HALF_W,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HALF_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef WIDEN16TO32_SEXT_EN
    input  logic                  in_sext,
`endif
    input  logic                  flush,
    output logic [2*HALF_W-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W = 2 * HALF_W;

    width_state_e        state_q;
    logic [HALF_W-1:0]   half_q;
    logic [W-1:0]        out_data_q;
    logic                out_valid_q;

    logic                accept;
    logic [W-1:0]        word_d;
    logic [W-1:0]        sext_d;

    // in_ready depends on state alone so no path exists from out_ready;
    // flush suppresses acceptance in both FIRST and SECOND.
    assign in_ready = (state_q != FULL);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        word_d = '0;
        if (LOW_FIRST)
            word_d = {in_data, half_q};
        else
            word_d = {half_q, in_data};
    end

    assign sext_d = {{HALF_W{in_data[HALF_W-1]}}, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FIRST;
            half_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FIRST: begin
                    if (accept) begin
`ifdef WIDEN16TO32_SEXT_EN
                        if (in_sext) begin
                            out_data_q  <= sext_d;
                            out_valid_q <= 1'b1;
                            state_q     <= FULL;
                        end else begin
                            half_q  <= in_data;
                            state_q <= SECOND;
                        end
`else
                        half_q  <= in_data;
                        state_q <= SECOND;
`endif
                    end
                end
                SECOND: begin
                    if (flush) begin
                        half_q  <= '0;
                        state_q <= FIRST;
                    end else if (accept) begin
                        out_data_q  <= word_d;
                        out_valid_q <= 1'b1;
                        state_q     <= FULL;
                    end
                end
                FULL: begin
                    // out_data_q keeps its value after the transfer
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= FIRST;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= FIRST;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifndef WIDEN16TO32_SEXT_EN
    logic unused_sext;
    assign unused_sext = ^sext_d;
`endif

endmodule

// File: tb/tb_widen16to32.sv
// Directed checks of widen16to32 with both beat orders driven from shared stimulus.
module tb_widen16to32;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_sext;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [31:0] held;

    int total;
    int bad;

    widen16to32 #(.HALF_W(16), .LOW_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a),
`ifdef WIDEN16TO32_SEXT_EN
        .in_sext(in_sext),
`endif
        .flush(flush), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready)
    );

    widen16to32 #(.HALF_W(16), .LOW_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b),
`ifdef WIDEN16TO32_SEXT_EN
        .in_sext(in_sext),
`endif
        .flush(flush), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; in_sext = 1'b0;
        step(); step();
        chk("rst_ovalid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_odata", out_data_a, 32'h0);
        chk("rst_iready", {31'd0, in_ready_a}, 32'd1);
        rst = 1'b0;
        step();

        // basic pack, both orders
        out_ready = 1'b1;
        beat(16'h1234);
        chk("sec_ovalid", {31'd0, out_valid_a}, 32'd0);
        chk("sec_iready", {31'd0, in_ready_a}, 32'd1);
        beat(16'hABCD);
        chk("full_ovalid", {31'd0, out_valid_a}, 32'd1);
        chk("low_first", out_data_a, 32'hABCD1234);
        chk("high_first", out_data_b, 32'h1234ABCD);
        chk("full_iready", {31'd0, in_ready_a}, 32'd0);
        step();
        chk("xfer_ovalid", {31'd0, out_valid_a}, 32'd0);
        chk("xfer_hold", out_data_a, 32'hABCD1234);
        chk("xfer_iready", {31'd0, in_ready_a}, 32'd1);

        // backpressure with a waiting beat
        out_ready = 1'b0;
        beat(16'hAAAA);
        beat(16'hBBBB);
        in_data = 16'h5555; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", out_data_a, 32'hBBBBAAAA);
            chk("bp_iready", {31'd0, in_ready_a}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_xfer", {31'd0, out_valid_a}, 32'd0);
        step();
        in_valid = 1'b0;
        beat(16'h6666);
        chk("bp_next", out_data_a, 32'h66665555);
        step();

        // flush in SECOND drops the half; beat in the same cycle is ignored
        beat(16'h1111);
        flush = 1'b1;
        beat(16'h9999);
        flush = 1'b0;
        chk("flush_iready", {31'd0, in_ready_a}, 32'd1);
        beat(16'h2222);
        chk("flush_mid", {31'd0, out_valid_a}, 32'd0);
        beat(16'h3333);
        chk("flush_word", out_data_a, 32'h33332222);
        step();

        // flush in FIRST blocks the beat; flush in FULL keeps the word
        flush = 1'b1;
        beat(16'h7777);
        flush = 1'b0;
        out_ready = 1'b0;
        beat(16'h4444);
        beat(16'h5555);
        chk("flush_first", out_data_a, 32'h55554444);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_v", {31'd0, out_valid_a}, 32'd1);
        chk("flush_full_d", out_data_a, 32'h55554444);
        out_ready = 1'b1;
        step();

        // async reset while a word is pending
        out_ready = 1'b0;
        beat(16'hBEEF);
        beat(16'hDEAD);
        chk("pend_word", out_data_a, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1;
        chk("arst_ovalid", {31'd0, out_valid_a}, 32'd0);
        chk("arst_odata", out_data_a, 32'h0);
        chk("arst_iready", {31'd0, in_ready_a}, 32'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        held = out_data_a;
        chk("arst_stay", held, 32'h0);

`ifdef WIDEN16TO32_SEXT_EN
        in_sext = 1'b1;
        beat(16'h8001);
        in_sext = 1'b0;
        chk("sext_v", {31'd0, out_valid_a}, 32'd1);
        chk("sext_neg_a", out_data_a, 32'hFFFF8001);
        chk("sext_neg_b", out_data_b, 32'hFFFF8001);
        step();
        in_sext = 1'b1;
        beat(16'h7FFF);
        in_sext = 1'b0;
        chk("sext_pos", out_data_a, 32'h00007FFF);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
